master_port: RTL and testbench

- Bus-side master interface that drives the serial slave port protocol used by the 4k RAM slaves.
- Accepts one parallel read or write request from a local device and serialises the 12-bit address and 8-bit write data LSB-first.
- For reads, deserialises the 8-bit read data returned by the slave.
- Supports slave split (holds the transaction) and a wait timeout that aborts with an error.

---
 rtl/master_port_if.sv | 39 +++
 rtl/master_port.sv | 174 +++++++++++++++++
 tb/tb_master_port.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/master_port_if.sv
// Signal bundle between a local requester, master_port and a serial 4k RAM slave port.
// The master modport is the port engine; the slave modport is everything around it.
interface master_port_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
);
   logic              dev_start;
   logic              dev_mode;
   logic [ADDR_W-1:0] dev_addr;
   logic [DATA_W-1:0] dev_wdata;
   logic              dev_busy;
   logic              dev_done;
   logic              dev_error;
   logic [DATA_W-1:0] dev_rdata;
   logic              read_en;
   logic              write_en;
   logic              master_valid;
   logic              master_ready;
   logic              tx_address;
   logic              tx_data;
   logic              slave_ready;
   logic              slave_valid;
   logic              rx_data;
   logic              split_en;

   modport master (
      input  dev_start, dev_mode, dev_addr, dev_wdata,
      input  slave_ready, slave_valid, rx_data, split_en,
      output dev_busy, dev_done, dev_error, dev_rdata,
      output read_en, write_en, master_valid, master_ready, tx_address, tx_data
   );

   modport slave (
      output dev_start, dev_mode, dev_addr, dev_wdata,
      output slave_ready, slave_valid, rx_data, split_en,
      input  dev_busy, dev_done, dev_error, dev_rdata,
      input  read_en, write_en, master_valid, master_ready, tx_address, tx_data
   );
endinterface

// File: rtl/master_port.sv
// Serial slave-port master: takes one parallel read/write request, serialises address
// and write data LSB-first, deserialises read data, and handles slave split and timeout.
module master_port #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          reset,
   master_port_if.master bus
);
   localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int BW   = $clog2(MAXW) + 1;
   localparam int CW   = $clog2(TIMEOUT);

   typedef enum logic [3:0] {
      S_IDLE, S_REQ, S_ADDR, S_WDATA, S_WACK, S_RWAIT, S_SPLIT, S_RDATA, S_DONE, S_ERR
   } state_t;

   state_t            r_state;
   logic              r_mode;
   logic [ADDR_W-1:0] r_addr_sh;
   logic [DATA_W-1:0] r_data_sh;
   logic [DATA_W-1:0] r_rx_sh;
   logic [CW-1:0]     r_cnt;
   logic [BW-1:0]     r_bit;

   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic [DATA_W-1:0] r_rdata;
   logic              r_read_en;
   logic              r_write_en;
   logic              r_mvalid;
   logic              r_mready;
   logic              r_tx_addr;
   logic              r_tx_data;

   state_t            w_nxt;
   logic              w_mode;
   logic [ADDR_W-1:0] w_addr_sh;
   logic [DATA_W-1:0] w_data_sh;
   logic [DATA_W-1:0] w_rx_sh;
   logic [CW-1:0]     w_cnt;
   logic [BW-1:0]     w_bit;
   logic              w_tmo;

   always_comb begin
      w_nxt     = r_state;
      w_mode    = r_mode;
      w_addr_sh = r_addr_sh;
      w_data_sh = r_data_sh;
      w_rx_sh   = r_rx_sh;
      w_cnt     = '0;
      w_bit     = '0;
      w_tmo     = (r_cnt == CW'(TIMEOUT - 1));
      case (r_state)
         S_IDLE: begin
            if (bus.dev_start) begin
               w_nxt     = S_REQ;
               w_mode    = bus.dev_mode;
               w_addr_sh = bus.dev_addr;
               w_data_sh = bus.dev_wdata;
            end
         end
         S_REQ: begin
            if (bus.slave_ready)  w_nxt = S_ADDR;
            else if (w_tmo)       w_nxt = S_ERR;
            else                  w_cnt = r_cnt + CW'(1);
         end
         // Shift registers are left unshifted on entry so bit0 shows on the first serial cycle.
         S_ADDR: begin
            if (r_bit == BW'(ADDR_W - 1)) begin
               w_nxt = r_mode ? S_WDATA : S_RWAIT;
            end else begin
               w_bit     = r_bit + BW'(1);
               w_addr_sh = r_addr_sh >> 1;
            end
         end
         S_WDATA: begin
            if (r_bit == BW'(DATA_W - 1)) begin
               w_nxt = S_WACK;
            end else begin
               w_bit     = r_bit + BW'(1);
               w_data_sh = r_data_sh >> 1;
            end
         end
         S_WACK: begin
            if (bus.slave_ready)  w_nxt = S_DONE;
            else if (w_tmo)       w_nxt = S_ERR;
            else                  w_cnt = r_cnt + CW'(1);
         end
         // Split freezes the wait count where it stood when the slave asked for it.
         S_RWAIT: begin
            if (bus.split_en) begin
               w_nxt = S_SPLIT;
               w_cnt = r_cnt;
            end else if (bus.slave_valid) begin
               w_nxt   = S_RDATA;
               w_bit   = BW'(1);
               w_rx_sh = {bus.rx_data, r_rx_sh[DATA_W-1:1]};
            end else if (w_tmo) begin
               w_nxt = S_ERR;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_SPLIT: begin
            w_cnt = r_cnt;
            if (!bus.split_en) w_nxt = S_RWAIT;
         end
         S_RDATA: begin
            w_rx_sh = {bus.rx_data, r_rx_sh[DATA_W-1:1]};
            if (r_bit == BW'(DATA_W - 1)) w_nxt = S_DONE;
            else                          w_bit = r_bit + BW'(1);
         end
         S_DONE:  w_nxt = S_IDLE;
         S_ERR:   w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with r_state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_mode     <= 1'b0;
         r_addr_sh  <= '0;
         r_data_sh  <= '0;
         r_rx_sh    <= '0;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_rdata    <= '0;
         r_read_en  <= 1'b0;
         r_write_en <= 1'b0;
         r_mvalid   <= 1'b0;
         r_mready   <= 1'b0;
         r_tx_addr  <= 1'b0;
         r_tx_data  <= 1'b0;
      end else begin
         r_state    <= w_nxt;
         r_mode     <= w_mode;
         r_addr_sh  <= w_addr_sh;
         r_data_sh  <= w_data_sh;
         r_rx_sh    <= w_rx_sh;
         r_cnt      <= w_cnt;
         r_bit      <= w_bit;
         r_busy     <= (w_nxt != S_IDLE);
         r_done     <= (w_nxt == S_DONE) || (w_nxt == S_ERR);
         r_error    <= (w_nxt == S_ERR);
         r_read_en  <= !w_mode && (w_nxt inside {S_REQ, S_ADDR, S_RWAIT, S_SPLIT, S_RDATA});
         r_write_en <= w_mode && (w_nxt inside {S_REQ, S_ADDR, S_WDATA, S_WACK});
         r_mvalid   <= (w_nxt inside {S_REQ, S_ADDR, S_WDATA});
         r_mready   <= (w_nxt inside {S_RWAIT, S_RDATA});
         r_tx_addr  <= (w_nxt == S_ADDR) && w_addr_sh[0];
         r_tx_data  <= (w_nxt == S_WDATA) && w_data_sh[0];
         if ((r_state == S_RDATA) && (w_nxt == S_DONE)) r_rdata <= w_rx_sh;
      end
   end

   assign bus.dev_busy     = r_busy;
   assign bus.dev_done     = r_done;
   assign bus.dev_error    = r_error;
   assign bus.dev_rdata    = r_rdata;
   assign bus.read_en      = r_read_en;
   assign bus.write_en     = r_write_en;
   assign bus.master_valid = r_mvalid;
   assign bus.master_ready = r_mready;
   assign bus.tx_address   = r_tx_addr;
   assign bus.tx_data      = r_tx_data;
endmodule

// File: tb/tb_master_port.sv
// Scoreboard bench for master_port: a TIMEOUT=64 instance for the main traffic and a
// TIMEOUT=8 instance for split and timeout-boundary behaviour.
module tb_master_port;
   localparam int AW = 12;
   localparam int DW = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t          sb_q[$];
   logic [DW-1:0] exp_rdata  = '0;
   logic [DW-1:0] exp_rdata8 = '0;

   master_port_if #(.ADDR_W(AW), .DATA_W(DW)) b  ();
   master_port_if #(.ADDR_W(AW), .DATA_W(DW)) b8 ();

   master_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .bus(b)
   );
   master_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut8 (
      .clk(clk), .reset(reset), .bus(b8)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      b.dev_start = 0; b.dev_mode = 0; b.dev_addr = '0; b.dev_wdata = '0;
      b.slave_ready = 0; b.slave_valid = 0; b.rx_data = 0; b.split_en = 0;
      b8.dev_start = 0; b8.dev_mode = 0; b8.dev_addr = '0; b8.dev_wdata = '0;
      b8.slave_ready = 0; b8.slave_valid = 0; b8.rx_data = 0; b8.split_en = 0;
      reset = 0;
      tick; tick;
      checks++;
      if ({b.dev_busy, b.dev_done, b.dev_error, b.read_en, b.write_en, b.master_valid,
           b.master_ready, b.tx_address, b.tx_data, b.dev_rdata} !== 17'h0) begin
         failures++;
         $display("FAIL reset_outs got=%b%b%b%b%b%b%b%b%b rdata=%h exp=all zero", b.dev_busy, b.dev_done,
                  b.dev_error, b.read_en, b.write_en, b.master_valid, b.master_ready, b.tx_address,
                  b.tx_data, b.dev_rdata);
      end
      reset = 1;
      tick;
      checks++;
      if ({b.dev_busy, b.dev_done, b8.dev_busy, b8.dev_done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle got=%b%b%b%b exp=0000", b.dev_busy, b.dev_done, b8.dev_busy, b8.dev_done);
      end
   endtask

   // Write on the TIMEOUT=64 instance with immediate handshakes; returns in the DONE cycle.
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit poke);
      exp_t e;
      e.err = 1'b0; e.rdata = exp_rdata; sb_q.push_back(e);
      b.dev_start = 1; b.dev_mode = 1; b.dev_addr = a; b.dev_wdata = d;
      tick;
      b.dev_start = 0;
      checks++;
      if ({b.master_valid, b.write_en, b.read_en, b.dev_busy} !== 4'b1101) begin
         failures++;
         $display("FAIL wr_req got=%b%b%b%b exp=1101", b.master_valid, b.write_en, b.read_en, b.dev_busy);
      end
      b.slave_ready = 1; tick; b.slave_ready = 0;
      for (int i = 0; i < AW; i++) begin
         checks++;
         if ({b.tx_address, b.master_valid, b.write_en, b.tx_data} !== {a[i], 3'b110}) begin
            failures++;
            $display("FAIL wr_addr bit%0d got=%b%b%b%b exp=%b110", i, b.tx_address, b.master_valid,
                     b.write_en, b.tx_data, a[i]);
         end
         if (poke && i == 3) begin
            b.dev_start = 1; b.dev_mode = 0; b.dev_addr = ~a; b.dev_wdata = ~d;
         end
         tick;
         b.dev_start = 0;
      end
      for (int i = 0; i < DW; i++) begin
         checks++;
         if ({b.tx_data, b.master_valid, b.write_en, b.tx_address} !== {d[i], 3'b110}) begin
            failures++;
            $display("FAIL wr_data bit%0d got=%b%b%b%b exp=%b110", i, b.tx_data, b.master_valid,
                     b.write_en, b.tx_address, d[i]);
         end
         tick;
      end
      checks++;
      if ({b.master_valid, b.write_en, b.dev_done} !== 3'b010) begin
         failures++;
         $display("FAIL wr_wack got=%b%b%b exp=010", b.master_valid, b.write_en, b.dev_done);
      end
      b.slave_ready = 1; tick; b.slave_ready = 0;
      checks++;
      if ({b.dev_done, b.write_en, b.master_valid, b.dev_busy} !== 4'b1001) begin
         failures++;
         $display("FAIL wr_done got=%b%b%b%b exp=1001", b.dev_done, b.write_en, b.master_valid, b.dev_busy);
      end
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL wr_sb got=empty exp=entry");
      end else begin
         e = sb_q.pop_front();
         if ({b.dev_error, b.dev_rdata} !== {e.err, e.rdata}) begin
            failures++;
            $display("FAIL wr_result got err=%b rdata=%h exp err=%b rdata=%h", b.dev_error, b.dev_rdata,
                     e.err, e.rdata);
         end
      end
   endtask

   // Read on the TIMEOUT=64 instance; slave_valid comes dly cycles into RWAIT.
   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int dly);
      exp_t e;
      e.err = 1'b0; e.rdata = d; sb_q.push_back(e);
      exp_rdata = d;
      b.dev_start = 1; b.dev_mode = 0; b.dev_addr = a; b.dev_wdata = '0;
      tick;
      b.dev_start = 0;
      checks++;
      if ({b.master_valid, b.read_en, b.write_en, b.master_ready} !== 4'b1100) begin
         failures++;
         $display("FAIL rd_req got=%b%b%b%b exp=1100", b.master_valid, b.read_en, b.write_en, b.master_ready);
      end
      b.slave_ready = 1; tick; b.slave_ready = 0;
      for (int i = 0; i < AW; i++) begin
         checks++;
         if ({b.tx_address, b.master_valid, b.read_en, b.master_ready} !== {a[i], 3'b110}) begin
            failures++;
            $display("FAIL rd_addr bit%0d got=%b%b%b%b exp=%b110", i, b.tx_address, b.master_valid,
                     b.read_en, b.master_ready, a[i]);
         end
         tick;
      end
      for (int i = 0; i <= dly; i++) begin
         checks++;
         if ({b.master_ready, b.master_valid, b.read_en, b.dev_done} !== 4'b1010) begin
            failures++;
            $display("FAIL rd_wait cyc%0d got=%b%b%b%b exp=1010", i, b.master_ready, b.master_valid,
                     b.read_en, b.dev_done);
         end
         if (i == dly) begin
            b.slave_valid = 1; b.rx_data = d[0];
         end
         tick;
         b.slave_valid = 0;
      end
      for (int i = 1; i < DW; i++) begin
         checks++;
         if ({b.master_ready, b.read_en, b.dev_done} !== 3'b110) begin
            failures++;
            $display("FAIL rd_data bit%0d got=%b%b%b exp=110", i, b.master_ready, b.read_en, b.dev_done);
         end
         b.rx_data = d[i];
         tick;
      end
      b.rx_data = 0;
      checks++;
      if ({b.dev_done, b.read_en, b.master_ready, b.master_valid} !== 4'b1000) begin
         failures++;
         $display("FAIL rd_done got=%b%b%b%b exp=1000", b.dev_done, b.read_en, b.master_ready, b.master_valid);
      end
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL rd_sb got=empty exp=entry");
      end else begin
         e = sb_q.pop_front();
         if ({b.dev_error, b.dev_rdata} !== {e.err, e.rdata}) begin
            failures++;
            $display("FAIL rd_result got err=%b rdata=%h exp err=%b rdata=%h", b.dev_error, b.dev_rdata,
                     e.err, e.rdata);
         end
      end
   endtask

   task automatic test_write;
      do_write(12'h3C7, 8'hA5, 1'b0);
      tick;
      checks++;
      if ({b.dev_busy, b.dev_done} !== 2'b00) begin
         failures++;
         $display("FAIL wr_idle got=%b%b exp=00", b.dev_busy, b.dev_done);
      end
   endtask

   task automatic test_read;
      do_read(12'h001, 8'h5A, 3);
      tick;
      checks++;
      if ({b.dev_busy, b.dev_done, b.dev_rdata} !== {2'b00, 8'h5A}) begin
         failures++;
         $display("FAIL rd_hold got=%b%b rdata=%h exp=00 rdata=5a", b.dev_busy, b.dev_done, b.dev_rdata);
      end
   endtask

   task automatic test_split;
      exp_t e;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = 12'h2B4; d = 8'hC3;
      e.err = 1'b0; e.rdata = d; sb_q.push_back(e);
      exp_rdata8 = d;
      b8.dev_start = 1; b8.dev_mode = 0; b8.dev_addr = a;
      tick;
      b8.dev_start = 0;
      b8.slave_ready = 1; tick; b8.slave_ready = 0;
      for (int i = 0; i < AW; i++) begin
         checks++;
         if (b8.tx_address !== a[i]) begin
            failures++;
            $display("FAIL sp_addr bit%0d got=%b exp=%b", i, b8.tx_address, a[i]);
         end
         tick;
      end
      tick; tick;
      // Split and slave_valid together: split must win.
      b8.split_en = 1; b8.slave_valid = 1; b8.rx_data = ~d[0];
      tick;
      b8.slave_valid = 0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({b8.master_ready, b8.read_en, b8.dev_done} !== 3'b010) begin
            failures++;
            $display("FAIL sp_hold cyc%0d got=%b%b%b exp=010", i, b8.master_ready, b8.read_en, b8.dev_done);
         end
         if (i == 9) b8.split_en = 0;
         tick;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({b8.master_ready, b8.read_en, b8.dev_done} !== 3'b110) begin
            failures++;
            $display("FAIL sp_rwait cyc%0d got=%b%b%b exp=110", i, b8.master_ready, b8.read_en, b8.dev_done);
         end
         if (i == 4) begin
            b8.slave_valid = 1; b8.rx_data = d[0];
         end
         tick;
         b8.slave_valid = 0;
      end
      for (int i = 1; i < DW; i++) begin
         b8.rx_data = d[i];
         tick;
      end
      b8.rx_data = 0;
      checks++;
      if (sb_q.size() == 0 || b8.dev_done !== 1'b1) begin
         failures++;
         $display("FAIL sp_done got done=%b sb=%0d exp done=1 sb>0", b8.dev_done, sb_q.size());
      end else begin
         e = sb_q.pop_front();
         if ({b8.dev_error, b8.dev_rdata} !== {e.err, e.rdata}) begin
            failures++;
            $display("FAIL sp_result got err=%b rdata=%h exp err=%b rdata=%h", b8.dev_error, b8.dev_rdata,
                     e.err, e.rdata);
         end
      end
      tick;
   endtask

   // Handshakes arriving exactly on the last allowed wait cycle must not time out.
   task automatic test_timeout_edge;
      exp_t e;
      logic [AW-1:0] a;
      a = 12'h555;
      e.err = 1'b0; e.rdata = exp_rdata8; sb_q.push_back(e);
      b8.dev_start = 1; b8.dev_mode = 1; b8.dev_addr = a; b8.dev_wdata = 8'h0F;
      tick;
      b8.dev_start = 0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({b8.master_valid, b8.write_en, b8.dev_done} !== 3'b110) begin
            failures++;
            $display("FAIL te_req cyc%0d got=%b%b%b exp=110", i, b8.master_valid, b8.write_en, b8.dev_done);
         end
         if (i == 7) b8.slave_ready = 1;
         tick;
         b8.slave_ready = 0;
      end
      for (int i = 0; i < AW; i++) begin
         checks++;
         if ({b8.tx_address, b8.master_valid} !== {a[i], 1'b1}) begin
            failures++;
            $display("FAIL te_addr bit%0d got=%b%b exp=%b1", i, b8.tx_address, b8.master_valid, a[i]);
         end
         tick;
      end
      repeat (DW) tick;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) b8.slave_ready = 1;
         tick;
         b8.slave_ready = 0;
      end
      checks++;
      if (sb_q.size() == 0 || b8.dev_done !== 1'b1) begin
         failures++;
         $display("FAIL te_done got done=%b sb=%0d exp done=1 sb>0", b8.dev_done, sb_q.size());
      end else begin
         e = sb_q.pop_front();
         if ({b8.dev_error, b8.dev_rdata} !== {e.err, e.rdata}) begin
            failures++;
            $display("FAIL te_result got err=%b rdata=%h exp err=%b rdata=%h", b8.dev_error, b8.dev_rdata,
                     e.err, e.rdata);
         end
      end
      tick;
   endtask

   task automatic test_timeout_err;
      exp_t e;
      e.err = 1'b1; e.rdata = exp_rdata; sb_q.push_back(e);
      b.dev_start = 1; b.dev_mode = 1; b.dev_addr = 12'hABC; b.dev_wdata = 8'h77;
      tick;
      b.dev_start = 0;
      for (int i = 0; i < 64; i++) begin
         checks++;
         if ({b.master_valid, b.write_en, b.dev_done} !== 3'b110) begin
            failures++;
            $display("FAIL to_req cyc%0d got=%b%b%b exp=110", i, b.master_valid, b.write_en, b.dev_done);
         end
         tick;
      end
      checks++;
      if ({b.read_en, b.write_en, b.master_valid, b.master_ready, b.tx_address, b.tx_data, b.dev_busy} !== 7'b0000001) begin
         failures++;
         $display("FAIL to_bus got=%b%b%b%b%b%b%b exp=0000001", b.read_en, b.write_en, b.master_valid,
                  b.master_ready, b.tx_address, b.tx_data, b.dev_busy);
      end
      checks++;
      if (sb_q.size() == 0 || b.dev_done !== 1'b1) begin
         failures++;
         $display("FAIL to_done got done=%b sb=%0d exp done=1 sb>0", b.dev_done, sb_q.size());
      end else begin
         e = sb_q.pop_front();
         if ({b.dev_error, b.dev_rdata} !== {e.err, e.rdata}) begin
            failures++;
            $display("FAIL to_result got err=%b rdata=%h exp err=%b rdata=%h", b.dev_error, b.dev_rdata,
                     e.err, e.rdata);
         end
      end
      tick;
      checks++;
      if ({b.dev_done, b.dev_error, b.dev_busy} !== 3'b000) begin
         failures++;
         $display("FAIL to_idle got=%b%b%b exp=000", b.dev_done, b.dev_error, b.dev_busy);
      end
   endtask

   task automatic test_reset_mid;
      b.dev_start = 1; b.dev_mode = 1; b.dev_addr = 12'h3C7; b.dev_wdata = 8'hA5;
      tick;
      b.dev_start = 0;
      b.slave_ready = 1; tick; b.slave_ready = 0;
      repeat (5) tick;
      reset = 0;
      #1;
      checks++;
      if ({b.dev_busy, b.dev_done, b.dev_error, b.read_en, b.write_en, b.master_valid,
           b.master_ready, b.tx_address, b.tx_data, b.dev_rdata} !== 17'h0) begin
         failures++;
         $display("FAIL rm_outs got=%b%b%b%b%b%b%b%b%b rdata=%h exp=all zero", b.dev_busy, b.dev_done,
                  b.dev_error, b.read_en, b.write_en, b.master_valid, b.master_ready, b.tx_address,
                  b.tx_data, b.dev_rdata);
      end
      exp_rdata = '0;
      exp_rdata8 = '0;
      tick;
      reset = 1;
      tick;
      checks++;
      if ({b.dev_busy, b.dev_done, b.master_valid} !== 3'b000) begin
         failures++;
         $display("FAIL rm_idle got=%b%b%b exp=000", b.dev_busy, b.dev_done, b.master_valid);
      end
      do_write(12'h0F0, 8'h3C, 1'b0);
      tick;
   endtask

   task automatic test_back_to_back;
      do_write(12'h8E1, 8'h96, 1'b1);
      // Strobe in the DONE cycle is ignored.
      b.dev_start = 1; b.dev_mode = 0; b.dev_addr = 12'h7FF;
      tick;
      b.dev_start = 0;
      checks++;
      if ({b.dev_busy, b.master_valid, b.dev_done} !== 3'b000) begin
         failures++;
         $display("FAIL b2b_ignore got=%b%b%b exp=000", b.dev_busy, b.master_valid, b.dev_done);
      end
      do_read(12'h7FF, 8'hE7, 0);
      tick;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_write;
      test_read;
      test_split;
      test_timeout_edge;
      test_timeout_err;
      test_reset_mid;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
